// File: rtl/vector_pkg.sv
// Shared types and width helpers for the serial-to-packed vector collector.
package vector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Bits needed to hold a lane count in 0..n.
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to address lanes 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_collector.sv
// Gathers serial elements into a zero-padded packed vector and presents it
// to a downstream adder with a valid/ready handshake.
module vector_collector
  import vector_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 8,
  parameter int unsigned INPUT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [INPUT_WIDTH-1:0]              in_data,
  input  logic                                in_valid,
  input  logic                                in_last,
  output logic                                in_ready,
  output logic [NUM_INPUTS*INPUT_WIDTH-1:0]   out_vector,
  output logic [count_width(NUM_INPUTS)-1:0]  out_count,
  output logic                                out_valid,
  input  logic                                out_ready
);

  localparam int unsigned IDX_W = idx_width(NUM_INPUTS);
  localparam int unsigned CNT_W = count_width(NUM_INPUTS);

  state_t state_q;
  state_t state_d;
  logic   in_ready_d;
  logic   out_valid_d;

  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] lanes_q;
  logic [IDX_W-1:0]                       idx_q;

  logic accept;
  logic close;
  logic release_vec;

  // in_ready is only high in COLLECT, so accept/close cannot fire in PRESENT.
  assign accept      = in_valid & in_ready;
  assign close       = accept & (in_last | (idx_q == IDX_W'(NUM_INPUTS - 1)));
  assign release_vec = out_valid & out_ready;

  assign out_vector  = lanes_q;

  // State register; handshake flags are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (close)       state_d = PRESENT;
      PRESENT: if (release_vec) state_d = COLLECT;
    endcase
  end

  // Output decode of the upcoming state, captured by the state register.
  always_comb begin
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_d)
      COLLECT: in_ready_d  = 1'b1;
      PRESENT: out_valid_d = 1'b1;
    endcase
  end

  // Lane storage: cleared on release so unused lanes pad the sum with zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes_q   <= '0;
      idx_q     <= '0;
      out_count <= '0;
    end else if (release_vec) begin
      lanes_q   <= '0;
      idx_q     <= '0;
      out_count <= '0;
    end else if (accept) begin
      lanes_q[idx_q] <= in_data;
      if (close) begin
        idx_q     <= '0;
        out_count <= CNT_W'(idx_q) + CNT_W'(1);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vector_collector.sv
// Directed and randomized self-checking bench for vector_collector (8 x 8-bit lanes).
module tb_vector_collector;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] out_vector;
  logic [3:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int applied    = 0;
  int miscompares = 0;

  vector_collector #(.NUM_INPUTS(8), .INPUT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_vector (out_vector),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  function automatic int lane_sum(input logic [63:0] v);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(v[i*8 +: 8]);
    return s;
  endfunction

  initial begin
    logic [63:0] m_vec;
    logic        m_collect;
    int          m_idx;
    int          m_cnt;
    int          elems_left;
    int          cyc;
    logic        iv;
    logic        il;
    logic        ordy;
    logic [7:0]  d;

    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_vector", out_vector, 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", in_ready, 0);
    tick();
    check("rel_in_ready_after_edge", in_ready, 1);

    // Full vector 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k);
      tick();
      if (k == 7) check("full_no_early_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    check("full_vector", out_vector, 64'h0807060504030201);
    check("full_count", out_count, 8);
    tick();
    check("full_drain_valid", out_valid, 0);
    check("full_drain_ready", in_ready, 1);
    check("full_drain_cleared", out_vector, 0);

    // Early close with in_last on the second element
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("short_vector", out_vector, 64'h000000000000BBAA);
    check("short_count", out_count, 2);
    tick();

    // Back-pressure while upstream keeps offering data
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(8'(8'h11 + k), 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_vector", out_vector, 64'h1817161514131211);
      check("bp_count", out_count, 8);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_cleared", out_vector, 0);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_lane0", out_vector, 64'hEE);
    check("bp_next_count", out_count, 1);
    tick();

    // in_last without in_valid must be ignored
    in_last = 1'b1;
    tick();
    in_last = 1'b0;
    check("idle_last_valid", out_valid, 0);
    check("idle_last_ready", in_ready, 1);

    // Single element closed by in_last
    send(8'h7F, 1'b1);
    check("single_vector", out_vector, 64'h7F);
    check("single_count", out_count, 1);
    tick();

    // in_last on the final lane behaves like a full vector
    for (int k = 0; k < 7; k++) send(8'(8'h31 + k), 1'b0);
    send(8'h38, 1'b1);
    check("last_on_top_vector", out_vector, 64'h3837363534333231);
    check("last_on_top_count", out_count, 8);
    tick();

    // Reset mid-vector discards the partial vector
    out_ready = 1'b0;
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_vector", out_vector, 0);
    check("midrst_count", out_count, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(8'(8'h51 + k), 1'b0);
    check("post_rst_vector", out_vector, 64'h5857565554535251);
    check("post_rst_count", out_count, 8);
    tick();

    // Reset while a vector is pending
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(8'(8'h61 + k), 1'b0);
    check("pend_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("pend_rst_valid", out_valid, 0);
    check("pend_rst_vector", out_vector, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("pend_rel_ready", in_ready, 1);
    check("pend_rel_valid", out_valid, 0);

    // Random handshakes against a reference model
    m_vec      = '0;
    m_collect  = 1'b1;
    m_idx      = 0;
    m_cnt      = 0;
    elems_left = 10000;
    cyc        = 0;
    while ((elems_left > 0 || !m_collect) && cyc < 60000) begin
      iv   = (elems_left > 0) && ($urandom_range(0, 1) == 1);
      d    = 8'($urandom);
      il   = ($urandom_range(0, 6) == 0);
      ordy = ($urandom_range(0, 1) == 1);
      in_valid  = iv;
      in_data   = d;
      in_last   = il;
      out_ready = ordy;
      check("rnd_in_ready", in_ready, m_collect);
      if (!m_collect && ordy) begin
        check("rnd_vector", out_vector, m_vec);
        check("rnd_count", out_count, m_cnt);
        check("rnd_sum", lane_sum(out_vector), lane_sum(m_vec));
      end
      if (m_collect) begin
        if (iv) begin
          m_vec[m_idx*8 +: 8] = d;
          elems_left--;
          if (il || m_idx == 7) begin
            m_collect = 1'b0;
            m_cnt     = m_idx + 1;
            m_idx     = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (ordy) begin
        m_vec     = '0;
        m_collect = 1'b1;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("rnd_completed", (elems_left == 0) && m_collect, 1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_collector.md
VECTOR_COLLECTOR -- requirements
Module: vector_collector

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 8, giving the number of lanes per packed vector (legal range 1..256).
REQ-002 The block SHALL have parameter INPUT_WIDTH, default 8, giving the bit width of each lane.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port in_data  input  INPUT_WIDTH  serial element from the upstream source.
REQ-006 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-007 The block SHALL have port in_last  input  1  the current element closes the vector early.
REQ-008 The block SHALL have port in_ready  output  1  the block accepts an element this cycle.
REQ-009 The block SHALL have port out_vector  output  NUM_INPUTS*INPUT_WIDTH  packed vector for the downstream adder, with lane k at bits k*INPUT_WIDTH +: INPUT_WIDTH.
REQ-010 The block SHALL have port out_count  output  clog2(NUM_INPUTS+1)  number of populated lanes.
REQ-011 The block SHALL have port out_valid  output  1  out_vector and out_count are valid.
REQ-012 The block SHALL have port out_ready  input  1  the downstream consumer takes the vector.

Function
REQ-013 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; an output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-014 The FSM SHALL have exactly two states: COLLECT (in_ready=1, out_valid=0) and PRESENT (in_ready=0, out_valid=1).
REQ-015 in_ready and out_valid SHALL be decoded from the registered state only, with no combinational path from in_valid or out_ready.
REQ-016 In COLLECT, each input transfer SHALL write in_data into lane idx and increment idx, starting from idx=0.
REQ-017 COLLECT SHALL move to PRESENT on the transfer where idx==NUM_INPUTS-1 or in_last=1, and out_count SHALL then equal idx+1.
REQ-018 out_valid SHALL rise on the cycle after the closing transfer (latency 1).
REQ-019 Lanes not written in a vector SHALL read as 0, so that a downstream sum is unaffected by padding.
REQ-020 While out_valid=1 and out_ready=0, out_vector and out_count SHALL hold stable.
REQ-021 On an output transfer, the block SHALL clear all lanes to 0, set idx to 0, and return to COLLECT on the next cycle.
REQ-022 Peak throughput SHALL be one vector per (elements+1) cycles.
REQ-023 in_last=1 on the first element SHALL produce out_count=1.
REQ-024 in_last=1 on lane NUM_INPUTS-1 SHALL be equivalent to a full vector.
REQ-025 in_last SHALL be ignored when in_valid=0.
REQ-026 out_ready asserted during COLLECT SHALL have no effect.
REQ-027 in_valid asserted during PRESENT SHALL not be accepted and SHALL not alter any state.
REQ-028 When NUM_INPUTS=1, every accepted element SHALL close a vector.

Reset
REQ-029 Assertion of rst_n=0 SHALL immediately force state=COLLECT, idx=0, all lanes=0, out_count=0, and out_valid=0.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after rst_n deasserts.
REQ-031 Reset mid-vector or mid-PRESENT SHALL discard the partial or pending vector, with no output transfer occurring.

Structure
REQ-032 A shared package vector_pkg SHALL hold the FSM state typedef (COLLECT, PRESENT) and a count-width helper constant function.
REQ-033 The module SHALL be implemented as a single module with no sub-modules; its out_vector SHALL connect directly to the downstream adder's packed input.

Verification
REQ-034 Scenario: reset, then feed 1..8 back-to-back with out_ready=1 -> out_vector=0x0807060504030201, out_count=8, out_valid high 1 cycle after the 8th accept.
REQ-035 Scenario: feed 0xAA, 0xBB with in_last on 0xBB -> out_vector=0x000000000000BBAA, out_count=2.
REQ-036 Scenario: full vector with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable for the 5 cycles, nothing accepted; after out_ready=1, next vector starts at lane 0.
REQ-037 Scenario: single element 0x7F with in_last=1 -> out_count=1, out_vector=0x7F.
REQ-038 Scenario: rst_n pulsed low after 3 accepts -> out_valid=0 and lanes cleared at once; next 8 elements form a clean vector with no residue.
REQ-039 Scenario: random in_valid/out_ready with 10k elements -> scoreboard matches the packed lanes and the downstream sum of each vector.
